// File: rtl/wfg_core_pkg.sv
// Shared types and limits for the waveform-generator timing core.
// Holds the FSM state encoding and the maximum supported channel count.
package wfg_core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } wfg_core_state_t;

   localparam int MAX_CH = 8;

endpackage

// File: rtl/wfg_core_chan_cnt.sv
// One sync channel: counts subcycle ticks, emits a registered sync pulse on wrap.
// hit_o is the combinational "this tick wraps" flag, used by the burst counter.
module wfg_core_chan_cnt #(
   parameter int CNTW = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            tick_i,
   input  logic            clr_i,
   input  logic [CNTW-1:0] thr_i,
   output logic            hit_o,
   output logic            sync_o,
   output logic [CNTW-1:0] cnt_o
);

   logic [CNTW-1:0] cnt_q;
   logic            sync_q;

   assign hit_o = tick_i && (cnt_q == thr_i);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         sync_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q  <= '0;
         sync_q <= 1'b0;
      end else begin
         sync_q <= hit_o;
         if (tick_i) begin
            cnt_q <= hit_o ? '0 : cnt_q + CNTW'(1);
         end
      end
   end

   assign sync_o = sync_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/wfg_core_multi.sv
// Multi-channel waveform-generator timing core: subcycle divider plus NUM_CH sync dividers.
// Optional one-shot burst mode is built when WFG_CORE_ONESHOT_EN is defined.
module wfg_core_multi
   import wfg_core_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SUBW   = 16,
   parameter int CNTW   = 8,
   parameter int BURSTW = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   en_i,
   input  logic                   oneshot_i,
   input  logic [BURSTW-1:0]      burst_len_i,
   input  logic [SUBW-1:0]        subcycle_thr_i,
   input  logic [NUM_CH*CNTW-1:0] sync_thr_i,
   output logic                   wfg_core_start_o,
   output logic                   wfg_core_subcycle_o,
   output logic [NUM_CH-1:0]      wfg_core_sync_o,
   output logic [CNTW-1:0]        wfg_core_subcycle_cnt_o,
   output logic                   active_o,
   output logic                   done_o
);

   wfg_core_state_t        state_q, state_d;
   logic [SUBW-1:0]        sthr_q;
   logic [NUM_CH*CNTW-1:0] cthr_q;
   logic [SUBW-1:0]        sc_q;
   logic                   start_q;
   logic                   sub_q;
   logic                   active_q;
   logic                   done_q;
   logic                   done_d;

   logic                   run_go;
   logic                   chan_clr;
   logic                   sub_hit;
   logic                   hit0;
   logic [NUM_CH-1:0]      sync_w;
   logic [CNTW-1:0]        ch0_cnt;

   // Counters advance on edges that land in a RUN cycle; a burst that has
   // already signalled done_o stops counting and leaves for DONE.
   assign run_go   = en_i && ((state_q == START) || ((state_q == RUN) && !done_q));
   assign chan_clr = !run_go;
   assign sub_hit  = run_go && (sc_q == sthr_q);

   // NOTE: every branch assigns state_d via the default on the first line, so
   // no latch is inferred in this combinational block.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en_i) state_d = START;
         START:   state_d = en_i ? RUN : IDLE;
         RUN: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (done_q) begin
               state_d = DONE;
            end
         end
         DONE:    if (!en_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         sthr_q   <= '0;
         cthr_q   <= '0;
         sc_q     <= '0;
         start_q  <= 1'b0;
         sub_q    <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= (state_d == START);
         active_q <= (state_d == START) || (state_d == RUN);
         sub_q    <= sub_hit;
         done_q   <= done_d;
         if (state_d == START) begin
            sthr_q <= subcycle_thr_i;
            cthr_q <= sync_thr_i;
         end
         if (!run_go) begin
            sc_q <= '0;
         end else begin
            sc_q <= sub_hit ? '0 : sc_q + SUBW'(1);
         end
      end
   end

`ifdef WFG_CORE_ONESHOT_EN
   logic              oneshot_q;
   logic [BURSTW-1:0] blen_q;
   logic [BURSTW-1:0] bcnt_q;
   logic              burst_last;

   // A programmed length of 0 behaves as a single-pulse burst.
   assign burst_last = (blen_q == '0) ? (bcnt_q == '0) : (bcnt_q == blen_q - BURSTW'(1));
   assign done_d     = run_go && oneshot_q && hit0 && burst_last;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         oneshot_q <= 1'b0;
         blen_q    <= '0;
         bcnt_q    <= '0;
      end else begin
         if (state_d == START) begin
            oneshot_q <= oneshot_i;
            blen_q    <= burst_len_i;
         end
         if (!run_go) begin
            bcnt_q <= '0;
         end else if (oneshot_q && hit0) begin
            bcnt_q <= bcnt_q + BURSTW'(1);
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{oneshot_i, burst_len_i, hit0};
   assign done_d     = 1'b0;
`endif

   for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
      if (c < NUM_CH) begin : g_on
         if (c == 0) begin : g_lead
            wfg_core_chan_cnt #(.CNTW(CNTW)) u_chan (
               .clk_i  (wb_clk_i),
               .rst_i  (wb_rst_i),
               .tick_i (sub_hit),
               .clr_i  (chan_clr),
               .thr_i  (cthr_q[c*CNTW +: CNTW]),
               .hit_o  (hit0),
               .sync_o (sync_w[c]),
               .cnt_o  (ch0_cnt)
            );
         end else begin : g_follow
            logic            hit_unused;
            logic [CNTW-1:0] cnt_unused;
            wfg_core_chan_cnt #(.CNTW(CNTW)) u_chan (
               .clk_i  (wb_clk_i),
               .rst_i  (wb_rst_i),
               .tick_i (sub_hit),
               .clr_i  (chan_clr),
               .thr_i  (cthr_q[c*CNTW +: CNTW]),
               .hit_o  (hit_unused),
               .sync_o (sync_w[c]),
               .cnt_o  (cnt_unused)
            );
         end
      end
   end

   assign wfg_core_start_o        = start_q;
   assign wfg_core_subcycle_o     = sub_q;
   assign wfg_core_sync_o         = sync_w;
   assign wfg_core_subcycle_cnt_o = ch0_cnt;
   assign active_o                = active_q;
   assign done_o                  = done_q;

endmodule

// File: tb/tb_wfg_core_multi.sv
// Self-checking bench for wfg_core_multi: closed-form period model, random configurations.
// Burst checks follow WFG_CORE_ONESHOT_EN the same way the design build does.
module tb_wfg_core_multi;

   localparam int NUM_CH = 4;
   localparam int SUBW   = 16;
   localparam int CNTW   = 8;
   localparam int BURSTW = 16;
   localparam int OW     = 4 + NUM_CH + CNTW;
`ifdef WFG_CORE_ONESHOT_EN
   localparam bit ONESHOT_BUILD = 1'b1;
`else
   localparam bit ONESHOT_BUILD = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   en_i = 1'b0;
   logic                   oneshot_i = 1'b0;
   logic [BURSTW-1:0]      burst_len_i = '0;
   logic [SUBW-1:0]        subcycle_thr_i = '0;
   logic [NUM_CH*CNTW-1:0] sync_thr_i = '0;
   logic                   start_o;
   logic                   sub_o;
   logic [NUM_CH-1:0]      sync_o;
   logic [CNTW-1:0]        cnt_o;
   logic                   active_o;
   logic                   done_o;

   int total = 0;
   int bad   = 0;

   // Configuration captured by the model at the start of each run.
   int cfg_st;
   int cfg_ct [NUM_CH];
   bit cfg_burst;
   int cfg_len;

   wfg_core_multi #(
      .NUM_CH(NUM_CH), .SUBW(SUBW), .CNTW(CNTW), .BURSTW(BURSTW)
   ) dut (
      .wb_clk_i                (clk),
      .wb_rst_i                (rst),
      .en_i                    (en_i),
      .oneshot_i               (oneshot_i),
      .burst_len_i             (burst_len_i),
      .subcycle_thr_i          (subcycle_thr_i),
      .sync_thr_i              (sync_thr_i),
      .wfg_core_start_o        (start_o),
      .wfg_core_subcycle_o     (sub_o),
      .wfg_core_sync_o         (sync_o),
      .wfg_core_subcycle_cnt_o (cnt_o),
      .active_o                (active_o),
      .done_o                  (done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [OW-1:0] observe();
      return {active_o, start_o, sub_o, done_o, sync_o, cnt_o};
   endfunction

   function automatic logic [NUM_CH*CNTW-1:0] mk_thr(input int v0, input int v1,
                                                     input int v2, input int v3);
      logic [NUM_CH*CNTW-1:0] t;
      int v [4];
      v = '{v0, v1, v2, v3};
      t = '0;
      for (int c = 0; c < NUM_CH; c++) t[c*CNTW +: CNTW] = CNTW'(v[c]);
      return t;
   endfunction

   // Expected outputs in run cycle n (n=0 is the START cycle): subcycle pulses
   // every P cycles, channel c every P*(thr_c+1) cycles, burst ends after
   // len ch0 syncs.
   function automatic logic [OW-1:0] expect_at(input int n);
      logic [NUM_CH-1:0] s;
      logic [CNTW-1:0]   cv;
      int p, m, d;
      bit sub, dn;
      p = cfg_st + 1;
      d = cfg_len * p * (cfg_ct[0] + 1);
      if (n == 0) return {1'b1, 1'b1, 2'b00, {NUM_CH{1'b0}}, {CNTW{1'b0}}};
      if (cfg_burst && n > d) return '0;
      sub = (n % p) == 0;
      m   = n / p;
      for (int c = 0; c < NUM_CH; c++) s[c] = sub && ((m % (cfg_ct[c] + 1)) == 0);
      cv = CNTW'(m % (cfg_ct[0] + 1));
      dn = cfg_burst && (n == d);
      return {1'b1, 1'b0, sub, dn, s, cv};
   endfunction

   task automatic cmp(input string tag, input int n, input logic [OW-1:0] want);
      logic [OW-1:0] got;
      got = observe();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s n=%0d got=%h want=%h (act,start,sub,done,sync,cnt)", tag, n, got, want);
      end
   endtask

   task automatic begin_run(input int st, input logic [NUM_CH*CNTW-1:0] thr,
                            input bit osh, input int len, input string tag);
      subcycle_thr_i = SUBW'(st);
      sync_thr_i     = thr;
      oneshot_i      = osh;
      burst_len_i    = BURSTW'(len);
      cfg_st         = st;
      for (int c = 0; c < NUM_CH; c++) cfg_ct[c] = int'(thr[c*CNTW +: CNTW]);
      cfg_burst      = ONESHOT_BUILD && osh;
      cfg_len        = (len == 0) ? 1 : len;
      en_i           = 1'b1;
      @(negedge clk);
      cmp(tag, 0, expect_at(0));
   endtask

   task automatic run_cycles(input int from, input int to, input string tag);
      for (int n = from; n <= to; n++) begin
         @(negedge clk);
         cmp(tag, n, expect_at(n));
      end
   endtask

   task automatic stop_run(input string tag);
      en_i = 1'b0;
      @(negedge clk);
      cmp({tag, "_stop"}, -1, '0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      cmp("reset_hold", -1, '0);
      rst = 1'b0;
      @(negedge clk);
      cmp("reset_idle", -1, '0);
      begin_run(3, mk_thr(1, 0, 2, 3), 1'b0, 0, "reset_run");
      run_cycles(1, 6, "reset_run");
      #2 rst = 1'b1;
      #1 cmp("reset_async", -1, '0);
      en_i = 1'b0;
      @(negedge clk);
      cmp("reset_mid", -1, '0);
      rst = 1'b0;
      @(negedge clk);
      cmp("reset_release", -1, '0);
   endtask

   task automatic test_basic();
      begin_run(3, mk_thr(1, 0, 2, 0), 1'b0, 0, "basic");
      run_cycles(1, 24, "basic");
      stop_run("basic");
   endtask

   task automatic test_thr_zero();
      begin_run(0, mk_thr(0, 0, 0, 0), 1'b0, 0, "thr_zero");
      run_cycles(1, 10, "thr_zero");
      stop_run("thr_zero");
   endtask

   task automatic test_shadow();
      begin_run(3, mk_thr(1, 0, 1, 2), 1'b0, 0, "shadow");
      run_cycles(1, 3, "shadow");
      subcycle_thr_i = SUBW'(7);
      sync_thr_i     = mk_thr(0, 2, 0, 1);
      run_cycles(4, 16, "shadow");
      stop_run("shadow");
      begin_run(7, mk_thr(0, 2, 0, 1), 1'b0, 0, "shadow_new");
      run_cycles(1, 24, "shadow_new");
      stop_run("shadow_new");
   endtask

   task automatic test_oneshot();
      begin_run(1, mk_thr(0, 1, 0, 0), 1'b1, 3, "oneshot");
      run_cycles(1, 12, "oneshot");
      stop_run("oneshot");
      begin_run(0, mk_thr(1, 0, 0, 0), 1'b1, 0, "oneshot_len0");
      run_cycles(1, 6, "oneshot_len0");
      stop_run("oneshot_len0");
   endtask

   task automatic test_en_drop();
      begin_run(1, mk_thr(1, 0, 0, 0), 1'b0, 0, "en_drop");
      run_cycles(1, 3, "en_drop");
      stop_run("en_drop");
   endtask

   task automatic test_random();
      int st, len;
      bit osh;
      logic [NUM_CH*CNTW-1:0] thr;
      for (int i = 0; i < 8; i++) begin
         st  = int'($urandom_range(0, 3));
         osh = 1'($urandom_range(0, 1));
         len = int'($urandom_range(0, 3));
         thr = mk_thr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         begin_run(st, thr, osh, len, "random");
         run_cycles(1, 40, "random");
         stop_run("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_thr_zero();
      test_shadow();
      test_oneshot();
      test_en_drop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
